chip_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one `chip_bus` slave port among `NUM_MASTERS` requesting masters. It sits beside the bus interface instance, collects per-master `request` lines, drives one-hot `grant`, and bounds each master's tenure by a transfer quota and a no-`ready` watchdog. A one-cycle turnaround separates every change of ownership.

---
 rtl/chip_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_chip_bus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/chip_bus_arbiter.sv
// chip_bus_arbiter: round-robin owner selection for a shared chip_bus slave.
// Each tenure is bounded by a transfer quota (only enforced when another
// master is waiting) and by a watchdog on missing ready pulses. A single
// zero-grant turnaround cycle separates every change of ownership.
module chip_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_XFERS   = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         request,
  input  logic                           ready,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           bus_busy,
  output logic                           timeout_err
);

  localparam int OW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [7:0]             xfer_cnt, xfer_cnt_n;
  logic [15:0]            wdog_cnt, wdog_cnt_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [OW-1:0]          owner_n;
  logic                   bus_busy_n;
  logic                   timeout_err_n;

  logic [NUM_MASTERS-1:0] owner_onehot;
  logic                   others_waiting;
  logic                   rr_found;
  logic [OW-1:0]          rr_winner;
  logic [NUM_MASTERS-1:0] rr_grant;
  logic                   quota_hit;
  logic                   wdog_hit;

  // Decode the owner and look for competing requesters for the quota check.
  always_comb begin
    owner_onehot   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner;
    others_waiting = |(request & ~owner_onehot);
    quota_hit      = (xfer_cnt == 8'(MAX_XFERS - 1));
    wdog_hit       = (wdog_cnt == 16'(TIMEOUT - 1));
  end

  // Round-robin search starting just after the last owner so it re-wins only when alone.
  always_comb begin
    int            idx;
    logic [OW-1:0] pos;
    rr_found  = 1'b0;
    rr_winner = owner;
    idx       = 0;
    pos       = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = int'(owner) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      pos = OW'(idx);
      if (!rr_found && request[pos]) begin
        rr_found  = 1'b1;
        rr_winner = pos;
      end
    end
    rr_grant = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << rr_winner;
  end

  // Next-state and next-output logic; release beats watchdog beats preemption.
  always_comb begin
    state_n       = state;
    grant_n       = grant;
    owner_n       = owner;
    bus_busy_n    = bus_busy;
    xfer_cnt_n    = xfer_cnt;
    wdog_cnt_n    = wdog_cnt;
    timeout_err_n = 1'b0;
    case (state)
      IDLE, TURN: begin
        if (rr_found) begin
          state_n    = OWNED;
          grant_n    = rr_grant;
          owner_n    = rr_winner;
          bus_busy_n = 1'b1;
          xfer_cnt_n = '0;
          wdog_cnt_n = '0;
        end else begin
          state_n    = IDLE;
          grant_n    = '0;
          bus_busy_n = 1'b0;
        end
      end
      OWNED: begin
        if (!request[owner]) begin
          state_n    = TURN;
          grant_n    = '0;
          bus_busy_n = 1'b0;
        end else if (wdog_hit && !ready) begin
          state_n       = TURN;
          grant_n       = '0;
          bus_busy_n    = 1'b0;
          timeout_err_n = 1'b1;
        end else if (ready && quota_hit && others_waiting) begin
          state_n    = TURN;
          grant_n    = '0;
          bus_busy_n = 1'b0;
        end else if (ready) begin
          if (!quota_hit) xfer_cnt_n = xfer_cnt + 8'd1;
          wdog_cnt_n = '0;
        end else begin
          wdog_cnt_n = wdog_cnt + 16'd1;
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        bus_busy_n = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs are registered; reset clears them at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= OW'(NUM_MASTERS - 1);
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      xfer_cnt    <= '0;
      wdog_cnt    <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      owner       <= owner_n;
      bus_busy    <= bus_busy_n;
      timeout_err <= timeout_err_n;
      xfer_cnt    <= xfer_cnt_n;
      wdog_cnt    <= wdog_cnt_n;
    end
  end

endmodule

// File: tb/tb_chip_bus_arbiter.sv
// tb_chip_bus_arbiter: directed scoreboard bench for chip_bus_arbiter with
// 4 masters, a quota of 8 transfers and a 64-cycle watchdog.
module tb_chip_bus_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] request;
  logic       ready;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       bus_busy;
  logic       timeout_err;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       terr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  chip_bus_arbiter #(
    .NUM_MASTERS(4),
    .MAX_XFERS(8),
    .TIMEOUT(64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .request(request),
    .ready(ready),
    .grant(grant),
    .owner(owner),
    .bus_busy(bus_busy),
    .timeout_err(timeout_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL time_limit: simulation still running, required finish");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic logic [3:0] oh(input int m);
    logic [3:0] one;
    one = 4'b0001;
    return one << m;
  endfunction

  task automatic push_exp(input string tag, input logic [3:0] g, input logic [1:0] o, input logic t);
    exp_t e;
    e.tag   = tag;
    e.grant = g;
    e.owner = o;
    e.terr  = t;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    checks++;
    assert (sb.size() > 0) passes++;
    else begin
      fails++;
      $error("[TB] FAIL scoreboard_empty: got size %0d, required >0", sb.size());
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (grant === e.grant) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s grant: got %b, required %b", e.tag, grant, e.grant);
    end
    checks++;
    assert (owner === e.owner) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s owner: got %0d, required %0d", e.tag, owner, e.owner);
    end
    checks++;
    assert (bus_busy === (|e.grant)) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s bus_busy: got %b, required %b", e.tag, bus_busy, |e.grant);
    end
    checks++;
    assert (timeout_err === e.terr) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s timeout_err: got %b, required %b", e.tag, timeout_err, e.terr);
    end
  endtask

  // Drive inputs for the coming edge, queue what must appear after it, then compare.
  task automatic apply_stimulus(input logic [3:0] req, input logic rdy, input string tag,
                                input logic [3:0] g, input logic [1:0] o, input logic t);
    request = req;
    ready   = rdy;
    push_exp(tag, g, o, t);
    @(posedge clock);
    #1;
    check_output();
  endtask

  // Directed sequence of scenarios.
  initial begin
    reset   = 1'b1;
    request = 4'b0000;
    ready   = 1'b0;
    @(posedge clock);
    #1;
    push_exp("reset_values", 4'b0000, 2'd3, 1'b0);
    check_output();
    reset = 1'b0;

    // Single requester: grant next cycle, then one turnaround cycle, then idle.
    $display("[TB] single request and release");
    apply_stimulus(4'b0001, 1'b0, "first_grant", 4'b0001, 2'd0, 1'b0);
    apply_stimulus(4'b0001, 1'b0, "hold_grant", 4'b0001, 2'd0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, "release_turn", 4'b0000, 2'd0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, "release_idle", 4'b0000, 2'd0, 1'b0);

    // All masters requesting with ready every cycle: quota rotation from master 0.
    $display("[TB] quota rotation");
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 8; k++)
        apply_stimulus(4'b1111, 1'b1, "rotate_tenure", oh(t % 4), 2'(t % 4), 1'b0);
      if (t < 4)
        apply_stimulus(4'b1111, 1'b1, "rotate_turn", 4'b0000, 2'(t % 4), 1'b0);
    end
    apply_stimulus(4'b0000, 1'b0, "rotate_release", 4'b0000, 2'd0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, "rotate_idle", 4'b0000, 2'd0, 1'b0);

    // Lone owner keeps the bus past the quota; a newcomer preempts on the next ready.
    $display("[TB] saturated quota then preemption");
    apply_stimulus(4'b0100, 1'b0, "lone_grant", 4'b0100, 2'd2, 1'b0);
    for (int k = 0; k < 20; k++)
      apply_stimulus(4'b0100, 1'b1, "lone_keep", 4'b0100, 2'd2, 1'b0);
    apply_stimulus(4'b0101, 1'b0, "newcomer_wait", 4'b0100, 2'd2, 1'b0);
    apply_stimulus(4'b0101, 1'b1, "preempt_turn", 4'b0000, 2'd2, 1'b0);
    apply_stimulus(4'b0101, 1'b0, "preempt_new", 4'b0001, 2'd0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, "preempt_release", 4'b0000, 2'd0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, "preempt_idle", 4'b0000, 2'd0, 1'b0);

    // Watchdog: 64 owned cycles without ready abort the tenure.
    $display("[TB] watchdog abort");
    apply_stimulus(4'b0010, 1'b0, "wdog_grant", 4'b0010, 2'd1, 1'b0);
    for (int k = 0; k < 63; k++)
      apply_stimulus(4'b0010, 1'b0, "wdog_wait", 4'b0010, 2'd1, 1'b0);
    apply_stimulus(4'b0010, 1'b0, "wdog_abort", 4'b0000, 2'd1, 1'b1);
    apply_stimulus(4'b0010, 1'b0, "wdog_regrant", 4'b0010, 2'd1, 1'b0);
    apply_stimulus(4'b0010, 1'b0, "wdog_single_pulse", 4'b0010, 2'd1, 1'b0);

    // Asynchronous reset mid-tenure drops grant without waiting for an edge.
    $display("[TB] reset mid tenure");
    reset = 1'b1;
    #1;
    push_exp("async_reset", 4'b0000, 2'd3, 1'b0);
    check_output();
    @(posedge clock);
    #1;
    reset = 1'b0;
    apply_stimulus(4'b0110, 1'b0, "post_reset_rr", 4'b0010, 2'd1, 1'b0);

    // Release on the quota-completing ready with others pending: plain release.
    $display("[TB] release with final ready");
    for (int k = 0; k < 7; k++)
      apply_stimulus(4'b0110, 1'b1, "final_xfers", 4'b0010, 2'd1, 1'b0);
    apply_stimulus(4'b0100, 1'b1, "final_release", 4'b0000, 2'd1, 1'b0);
    apply_stimulus(4'b0100, 1'b0, "final_next", 4'b0100, 2'd2, 1'b0);

    // Round-robin wraps past the highest index back to master 0.
    $display("[TB] round robin wrap");
    apply_stimulus(4'b0000, 1'b0, "wrap_release", 4'b0000, 2'd2, 1'b0);
    apply_stimulus(4'b0011, 1'b0, "wrap_grant", 4'b0001, 2'd0, 1'b0);
    apply_stimulus(4'b0010, 1'b0, "wrap_turn", 4'b0000, 2'd0, 1'b0);
    apply_stimulus(4'b0010, 1'b0, "wrap_next", 4'b0010, 2'd1, 1'b0);
    apply_stimulus(4'b0000, 1'b0, "wrap_end_turn", 4'b0000, 2'd1, 1'b0);
    apply_stimulus(4'b0000, 1'b1, "wrap_end_idle", 4'b0000, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
